bcd_countdown_timer: RTL and testbench
======================================

BCD_COUNTDOWN_TIMER -- requirements
Module: bcd_countdown_timer

Interface
REQ-001 Parameter DIGITS, default 4, number of BCD digits (1..8).
REQ-002 Parameter TICK_DIV, default 2500000, clk cycles per countdown tick (>=2).
REQ-003 The block SHALL use reset nRst, asynchronous, active-high, and clock clk.
REQ-004 clk  input  1  system clock.
REQ-005 nRst  input  1  asynchronous, active-high reset.
REQ-006 inc  input  1  single-cycle pulse: increment the digit at the cursor (already debounced and edge-detected upstream).
REQ-007 dec  input  1  single-cycle pulse: decrement the digit at the cursor.
REQ-008 nxt  input  1  single-cycle pulse: advance the cursor, or abort from PAUSE.
REQ-009 run  input  1  single-cycle pulse: start/pause toggle.
REQ-010 value  output  4*DIGITS  BCD value; digit 0 = bits [3:0] = least significant.
REQ-011 cursor  output  clog2(DIGITS) (min 1)  index of the editable digit.
REQ-012 state  output  2  current FSM state encoding.
REQ-013 running  output  1  high while state is RUN.
REQ-014 done  output  1  one-cycle pulse when the count reaches zero.

Function
REQ-015 The FSM SHALL have four states: SET=0, RUN=1, PAUSE=2, DONE=3.
REQ-016 All outputs SHALL be registered; an input pulse SHALL take effect on the next clk edge (1-cycle latency).
REQ-017 If several pulses arrive in the same cycle, only the highest-priority one SHALL act: run > nxt > inc > dec.
REQ-018 SET + inc: digit[cursor] goes 0..9, then 9 wraps to 0, with no carry into other digits.
REQ-019 SET + dec: digit[cursor] decrements, 0 wraps to 9, with no borrow.
REQ-020 SET + nxt: cursor increments; DIGITS-1 wraps to 0.
REQ-021 SET + run with value != 0: go to RUN and clear the prescaler; with value == 0, stay in SET with no change.
REQ-022 The prescaler SHALL count 0..TICK_DIV-1 only in RUN, hold in PAUSE, and clear on entry to RUN from SET; a tick occurs in the cycle the prescaler equals TICK_DIV-1.
REQ-023 RUN + tick: value decrements by one as a multi-digit BCD number, with borrow propagating (e.g. 1000 -> 0999).
REQ-024 When a tick brings value to 0: go to DONE and assert done for exactly that one transition cycle.
REQ-025 RUN + run: go to PAUSE. If a tick coincides, the decrement SHALL be applied in the same cycle; a tick that reaches zero takes DONE instead.
REQ-026 In RUN, inc, dec and nxt SHALL be ignored.
REQ-027 PAUSE + run: return to RUN without clearing the prescaler.
REQ-028 PAUSE + nxt: go to SET, keeping value, with cursor = 0; PAUSE + inc/dec: ignored.
REQ-029 DONE: value holds 0; any of run, nxt, inc or dec returns to SET with cursor = 0 and value = 0.
REQ-030 value SHALL never hold a non-BCD nibble (A..F).

Reset
REQ-031 While nRst is high: state = SET, value = 0, cursor = 0, running = 0, done = 0, prescaler = 0, asynchronously.
REQ-032 Reset asserted mid-RUN SHALL abort the countdown with no done pulse.
REQ-033 After nRst falls, the first pulse SHALL be honoured at the next edge.

Structure
REQ-034 A shared package timer_pkg SHALL hold the state encoding constants and BCD_W = 4.
REQ-035 The prescaler SHALL be a sub-module tick_gen (parameter TICK_DIV; inputs clk, nRst, en, clr; output tick).
REQ-036 BCD multi-digit decrement SHALL be a generate loop over DIGITS inside bcd_countdown_timer.

Verification (bench uses DIGITS=4, TICK_DIV=4)
REQ-037 Edit: nxt x1, inc x11, dec x2 -> cursor = 1, value = 0x0000 then 0x0090 after wraps.
REQ-038 Run: set 0x0002, run -> after 4 clk, value = 0x0001; after 8 clk, value = 0x0000, state = DONE, done high for 1 cycle.
REQ-039 Borrow: set 0x1000, run, one tick -> 0x0999; run with value 0x0000 in SET -> state stays SET.
REQ-040 Pause: run mid-count at prescaler = 2, wait 20 clk with value unchanged, run -> next tick after 1 clk; nxt in PAUSE -> SET, value kept.
REQ-041 Simultaneous run + inc in SET -> RUN only, value unchanged; run coincident with a tick in RUN -> decrement applied, state = PAUSE.
REQ-042 nRst pulse during RUN at value 0x0005 -> all outputs reset immediately (asynchronously), no done.

Source files
------------

// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared state encoding and BCD digit helpers for the countdown timer
package timer_pkg;

    localparam int BCD_W = 4;

    localparam logic [1:0] ST_SET   = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    function automatic logic [BCD_W-1:0] bcd_up(input logic [BCD_W-1:0] d);
        return (d >= 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

    function automatic logic [BCD_W-1:0] bcd_down(input logic [BCD_W-1:0] d);
        return (d == 4'd0 || d > 4'd9) ? 4'd9 : d - 4'd1;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - prescaler producing one tick every TICK_DIV enabled clk cycles
module tick_gen #(
    parameter int TICK_DIV = 2500000
) (
    input  logic clk,
    input  logic nRst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    // Holds its count while disabled so a paused countdown resumes mid-period.
    always_ff @(posedge clk or posedge nRst) begin
        if (nRst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
        end
    end

    assign tick = en && (cnt == CNT_LAST);

endmodule

// File: rtl/bcd_countdown_timer.sv
// rtl/bcd_countdown_timer.sv - editable multi-digit BCD countdown timer with run/pause/done FSM
module bcd_countdown_timer
    import timer_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 2500000,
    localparam int CUR_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic                      clk,
    input  logic                      nRst,
    input  logic                      inc,
    input  logic                      dec,
    input  logic                      nxt,
    input  logic                      run,
    output logic [BCD_W*DIGITS-1:0]   value,
    output logic [CUR_W-1:0]          cursor,
    output logic [1:0]                state,
    output logic                      running,
    output logic                      done
);

    localparam logic [CUR_W-1:0] CUR_LAST = CUR_W'(DIGITS - 1);

    logic [BCD_W*DIGITS-1:0] value_dec;
    logic [BCD_W*DIGITS-1:0] value_nxt;
    logic [CUR_W-1:0]        cursor_nxt;
    logic [1:0]              state_nxt;
    logic                    done_nxt;
    logic                    tick;
    logic                    presc_en;
    logic                    presc_clr;
    logic                    hits_zero;

    assign presc_en  = (state == ST_RUN);
    assign presc_clr = (state == ST_SET) && run && (value != '0);

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .nRst (nRst),
        .en   (presc_en),
        .clr  (presc_clr),
        .tick (tick)
    );

    // A digit borrows exactly when every lower digit is zero, so no ripple chain is needed.
    for (genvar g = 0; g < DIGITS; g++) begin : g_dec
        logic             borrow_in;
        logic [BCD_W-1:0] digit;

        assign digit = value[g*BCD_W +: BCD_W];

        if (g == 0) begin : g_lsd
            assign borrow_in = 1'b1;
        end else begin : g_upper
            assign borrow_in = (value[g*BCD_W-1:0] == '0);
        end

        assign value_dec[g*BCD_W +: BCD_W] = borrow_in ? bcd_down(digit) : digit;
    end

    assign hits_zero = tick && (value_dec == '0);

    always_comb begin
        state_nxt  = state;
        value_nxt  = value;
        cursor_nxt = cursor;
        done_nxt   = 1'b0;
        case (state)
            ST_SET: begin
                if (run) begin
                    if (value != '0) begin
                        state_nxt = ST_RUN;
                    end
                end else if (nxt) begin
                    cursor_nxt = (cursor == CUR_LAST) ? '0 : cursor + 1'b1;
                end else if (inc || dec) begin
                    for (int i = 0; i < DIGITS; i++) begin
                        if (CUR_W'(i) == cursor) begin
                            value_nxt[i*BCD_W +: BCD_W] = inc ? bcd_up(value[i*BCD_W +: BCD_W])
                                                              : bcd_down(value[i*BCD_W +: BCD_W]);
                        end
                    end
                end
            end
            ST_RUN: begin
                // A pause that lands on a tick still takes the decrement; reaching zero wins over pause.
                if (hits_zero) begin
                    state_nxt = ST_DONE;
                    value_nxt = '0;
                    done_nxt  = 1'b1;
                end else begin
                    if (tick) begin
                        value_nxt = value_dec;
                    end
                    if (run) begin
                        state_nxt = ST_PAUSE;
                    end
                end
            end
            ST_PAUSE: begin
                if (run) begin
                    state_nxt = ST_RUN;
                end else if (nxt) begin
                    state_nxt  = ST_SET;
                    cursor_nxt = '0;
                end
            end
            default: begin
                value_nxt = '0;
                if (run || nxt || inc || dec) begin
                    state_nxt  = ST_SET;
                    cursor_nxt = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge nRst) begin
        if (nRst) begin
            state   <= ST_SET;
            value   <= '0;
            cursor  <= '0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            value   <= value_nxt;
            cursor  <= cursor_nxt;
            running <= (state_nxt == ST_RUN);
            done    <= done_nxt;
        end
    end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// tb/tb_bcd_countdown_timer.sv - directed self-checking bench for bcd_countdown_timer
module tb_bcd_countdown_timer;

    logic        clk;
    logic        nRst;
    logic        inc;
    logic        dec;
    logic        nxt;
    logic        run;
    logic [15:0] value;
    logic [1:0]  cursor;
    logic [1:0]  state;
    logic        running;
    logic        done;

    int checks   = 0;
    int failures = 0;

    bcd_countdown_timer #(
        .DIGITS   (4),
        .TICK_DIV (4)
    ) dut (
        .clk     (clk),
        .nRst    (nRst),
        .inc     (inc),
        .dec     (dec),
        .nxt     (nxt),
        .run     (run),
        .value   (value),
        .cursor  (cursor),
        .state   (state),
        .running (running),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // bits: {run, nxt, inc, dec}; applied for one edge, sampled 1 time unit after it
    task automatic pulse(input logic [3:0] p);
        @(negedge clk);
        {run, nxt, inc, dec} = p;
        @(posedge clk);
        #1;
        {run, nxt, inc, dec} = 4'b0000;
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        nRst = 1'b1;
        @(negedge clk);
        nRst = 1'b0;
    endtask

    localparam logic [3:0] P_RUN = 4'b1000;
    localparam logic [3:0] P_NXT = 4'b0100;
    localparam logic [3:0] P_INC = 4'b0010;
    localparam logic [3:0] P_DEC = 4'b0001;

    initial begin
        int saw_done;
        nRst = 1'b1;
        {run, nxt, inc, dec} = 4'b0000;
        #12;
        check("rst_state",   32'(state),   32'd0);
        check("rst_value",   32'(value),   32'h0);
        check("rst_cursor",  32'(cursor),  32'd0);
        check("rst_running", 32'(running), 32'd0);
        check("rst_done",    32'(done),    32'd0);
        @(negedge clk);
        nRst = 1'b0;

        // edit: cursor to digit 1, wrap it through 9 -> 0, then dec wraps 0 -> 9
        pulse(P_NXT);
        check("edit_cursor1", 32'(cursor), 32'd1);
        repeat (10) pulse(P_INC);
        check("edit_wrap10", 32'(value), 32'h0000);
        pulse(P_INC);
        check("edit_inc11", 32'(value), 32'h0010);
        repeat (2) pulse(P_DEC);
        check("edit_dec2", 32'(value), 32'h0090);
        check("edit_cursor_kept", 32'(cursor), 32'd1);
        repeat (2) pulse(P_NXT);
        check("cursor_3", 32'(cursor), 32'd3);
        pulse(P_NXT);
        check("cursor_wrap", 32'(cursor), 32'd0);

        // run with zero value stays in SET
        do_reset();
        pulse(P_RUN);
        check("zero_run_state", 32'(state), 32'd0);
        check("zero_run_running", 32'(running), 32'd0);

        // value 2; run+inc together -> run only
        repeat (2) pulse(P_INC);
        pulse(P_RUN | P_INC);
        check("prio_state", 32'(state), 32'd1);
        check("prio_value", 32'(value), 32'h0002);
        check("prio_running", 32'(running), 32'd1);
        wait_clk(4);
        check("run_tick1", 32'(value), 32'h0001);
        pulse(P_NXT);
        check("run_ignore_nxt_cursor", 32'(cursor), 32'd0);
        check("run_ignore_nxt_value", 32'(value), 32'h0001);
        wait_clk(3);
        check("run_zero_value", 32'(value), 32'h0000);
        check("run_zero_state", 32'(state), 32'd3);
        check("run_zero_done", 32'(done), 32'd1);
        check("run_zero_running", 32'(running), 32'd0);
        wait_clk(1);
        check("done_one_cycle", 32'(done), 32'd0);
        check("done_hold_state", 32'(state), 32'd3);
        pulse(P_INC);
        check("done_exit_state", 32'(state), 32'd0);
        check("done_exit_value", 32'(value), 32'h0000);

        // borrow 1000 -> 0999
        do_reset();
        repeat (3) pulse(P_NXT);
        pulse(P_INC);
        check("borrow_setup", 32'(value), 32'h1000);
        pulse(P_RUN);
        wait_clk(4);
        check("borrow_value", 32'(value), 32'h0999);

        // pause at prescaler 2, hold, resume, tick one clk later
        wait_clk(2);
        pulse(P_RUN);
        check("pause_state", 32'(state), 32'd2);
        check("pause_running", 32'(running), 32'd0);
        wait_clk(20);
        check("pause_hold_value", 32'(value), 32'h0999);
        pulse(P_RUN);
        check("resume_state", 32'(state), 32'd1);
        check("resume_value", 32'(value), 32'h0999);
        wait_clk(1);
        check("resume_tick", 32'(value), 32'h0998);

        // run coincident with a tick: decrement and pause
        wait_clk(3);
        pulse(P_RUN);
        check("tick_pause_value", 32'(value), 32'h0997);
        check("tick_pause_state", 32'(state), 32'd2);
        pulse(P_INC);
        check("pause_ignore_inc", 32'(value), 32'h0997);
        pulse(P_NXT);
        check("abort_state", 32'(state), 32'd0);
        check("abort_value", 32'(value), 32'h0997);
        check("abort_cursor", 32'(cursor), 32'd0);

        // asynchronous reset mid-run
        do_reset();
        repeat (5) pulse(P_INC);
        pulse(P_RUN);
        wait_clk(2);
        nRst = 1'b1;
        #1;
        check("async_state", 32'(state), 32'd0);
        check("async_value", 32'(value), 32'h0000);
        check("async_running", 32'(running), 32'd0);
        check("async_done", 32'(done), 32'd0);
        @(negedge clk);
        nRst = 1'b0;
        saw_done = 0;
        for (int i = 0; i < 10; i++) begin
            wait_clk(1);
            if (done) saw_done = 1;
        end
        check("no_done_after_rst", 32'(saw_done), 32'd0);
        pulse(P_INC);
        check("first_pulse_after_rst", 32'(value), 32'h0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
